// File: rtl/run_gen.sv
`timescale 1ns/1ps
// run_gen: serial run-length transmitter.
// Takes a run length over a vld/rdy handshake and sends one frame on `x`.
// A frame is `len` ones followed by GAP zeros. `x` drives the ones-run
// detector's serial input on the same clock.
//
// Parameters:
//   LEN_W  width of the run-length word (longest run = 2^LEN_W-1 ones)
//   GAP    zero cycles after each run, 1..15
//
// Ports:
//   c       clock, rising edge
//   r       asynchronous active-low reset
//   len     run length for the next frame
//   vld     len valid, held with len stable until accepted
//   rdy     transmitter can accept len this cycle (combinational)
//   x       registered serial output
//   busy    a frame is in progress
//   done    one-cycle pulse after the last gap cycle of each frame
//   frames  count of completed frames, wraps at 256
//           (present only when RUNGEN_FRAMECNT_EN is defined)
//
// Optional feature macro: RUNGEN_FRAMECNT_EN
module run_gen #(
  parameter int unsigned LEN_W = 4,
  parameter int unsigned GAP   = 1
) (
  input  logic             c,
  input  logic             r,
  input  logic [LEN_W-1:0] len,
  input  logic             vld,
  output logic             rdy,
  output logic             x,
  output logic             busy,
  output logic             done
`ifdef RUNGEN_FRAMECNT_EN
  ,
  output logic [7:0]       frames
`endif
);

  if (GAP < 1 || GAP > 15) begin : g_bad_gap
    $error("run_gen: GAP must be in the range 1..15");
  end

  localparam logic [3:0] GAP_LD = 4'(GAP - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ONES = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  state_t           st;
  logic [LEN_W-1:0] cnt;
  logic [3:0]       gcnt;
  logic             accept;

  // The last gap cycle is also a ready cycle, so back-to-back frames need
  // no idle cycle in between.
  assign rdy    = (st == ST_IDLE) || ((st == ST_GAP) && (gcnt == 4'd0));
  assign accept = vld && rdy;
  assign busy   = (st != ST_IDLE);

  always_ff @(posedge c or negedge r) begin
    if (!r) begin
      st     <= ST_IDLE;
      cnt    <= '0;
      gcnt   <= '0;
      x      <= 1'b0;
      done   <= 1'b0;
`ifdef RUNGEN_FRAMECNT_EN
      frames <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (st)
        ST_IDLE: begin
          x <= 1'b0;
          if (accept) begin
            if (len != '0) begin
              st  <= ST_ONES;
              x   <= 1'b1;
              cnt <= len - LEN_W'(1);
            end else begin
              // Zero-length request still sends a full gap.
              st   <= ST_GAP;
              x    <= 1'b0;
              gcnt <= GAP_LD;
            end
          end
        end

        ST_ONES: begin
          if (cnt != '0) begin
            cnt <= cnt - LEN_W'(1);
          end else begin
            st   <= ST_GAP;
            x    <= 1'b0;
            gcnt <= GAP_LD;
          end
        end

        ST_GAP: begin
          if (gcnt != 4'd0) begin
            gcnt <= gcnt - 4'd1;
          end else begin
            done   <= 1'b1;
`ifdef RUNGEN_FRAMECNT_EN
            frames <= frames + 8'd1;
`endif
            // Frame completes and, if a request is waiting, the next one
            // loads on the same edge exactly as it would from IDLE.
            if (accept) begin
              if (len != '0) begin
                st  <= ST_ONES;
                x   <= 1'b1;
                cnt <= len - LEN_W'(1);
              end else begin
                st   <= ST_GAP;
                x    <= 1'b0;
                gcnt <= GAP_LD;
              end
            end else begin
              st <= ST_IDLE;
            end
          end
        end

        default: begin
          st <= ST_IDLE;
          x  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_run_gen.sv
`timescale 1ns/1ps
module tb_run_gen;

  localparam int unsigned LEN_W   = 4;
  localparam int unsigned GAP     = 1;
  localparam int          LEN_MAX = (1 << LEN_W) - 1;
  localparam int          N_RAND  = 1500;

  logic             c = 1'b0;
  logic             r = 1'b0;
  logic [LEN_W-1:0] len = '0;
  logic             vld = 1'b0;
  logic             rdy;
  logic             x;
  logic             busy;
  logic             done;
`ifdef RUNGEN_FRAMECNT_EN
  logic [7:0]       frames;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // Reference timeline for the random test, indexed by clock edge number.
  bit exp_x    [0:2047];
  bit exp_busy [0:2047];
  bit exp_done [0:2047];

  run_gen #(.LEN_W(LEN_W), .GAP(GAP)) dut (
    .c    (c),
    .r    (r),
    .len  (len),
    .vld  (vld),
    .rdy  (rdy),
    .x    (x),
    .busy (busy),
    .done (done)
`ifdef RUNGEN_FRAMECNT_EN
    ,
    .frames (frames)
`endif
  );

  always #5 c = ~c;

  task automatic tick;
    @(posedge c);
    #1;
  endtask

  task automatic apply_reset;
    r   = 1'b0;
    vld = 1'b0;
    tick();
    tick();
    r = 1'b1;
  endtask

  function automatic logic [LEN_W-1:0] rand_len;
    int unsigned sel;
    sel = $urandom % 8;
    if (sel == 0)      rand_len = '0;
    else if (sel == 1) rand_len = LEN_W'(LEN_MAX);
    else               rand_len = LEN_W'($urandom_range(1, LEN_MAX));
  endfunction

  task automatic test_reset;
    logic [3:0] want;
    r   = 1'b0;
    vld = 1'b1;
    len = 4'd5;
    want = 4'b1000; // {rdy, busy, x, done}
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if ({rdy, busy, x, done} !== want) begin
        n_fail++;
        $display("FAIL reset_hold cyc %0d: got %b want %b", i, {rdy, busy, x, done}, want);
      end
    end
    vld = 1'b0;
    r   = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      n_checks++;
      if ({rdy, busy, x, done} !== want) begin
        n_fail++;
        $display("FAIL reset_idle cyc %0d: got %b want %b", i, {rdy, busy, x, done}, want);
      end
    end
  endtask

  task automatic test_single;
    logic [3:0] want;
    logic       prev_x;
    int         falls;
    apply_reset();
    len = 4'd3;
    vld = 1'b1;
    prev_x = 1'b0;
    falls  = 0;
    for (int i = 1; i <= 6; i++) begin
      tick();
      vld  = 1'b0;
      want = {i >= 4, i <= 4, i <= 3, i == 5};
      n_checks++;
      if ({rdy, busy, x, done} !== want) begin
        n_fail++;
        $display("FAIL single cyc %0d: got %b want %b", i, {rdy, busy, x, done}, want);
      end
      if (prev_x && !x) falls++;
      prev_x = x;
    end
    n_checks++;
    if (falls !== 1) begin
      n_fail++;
      $display("FAIL single_detect: got %0d pulses want 1", falls);
    end
  endtask

  task automatic test_back_to_back;
    logic [3:0] want;
    logic       prev_x;
    int         falls;
    apply_reset();
    len = 4'd2;
    vld = 1'b1;
    prev_x = 1'b0;
    falls  = 0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (i == 7) vld = 1'b0;
      want = {(i % 3 == 0) || (i >= 10), i <= 9,
              (i <= 9) && ((i - 1) % 3 != 2), (i == 4) || (i == 7) || (i == 10)};
      n_checks++;
      if ({rdy, busy, x, done} !== want) begin
        n_fail++;
        $display("FAIL b2b cyc %0d: got %b want %b", i, {rdy, busy, x, done}, want);
      end
      if (prev_x && !x) falls++;
      prev_x = x;
    end
    n_checks++;
    if (falls !== 3) begin
      n_fail++;
      $display("FAIL b2b_detect: got %0d pulses want 3", falls);
    end
  endtask

  task automatic test_zero_and_max;
    logic [3:0] want;
    logic       prev_x;
    int         falls;
    apply_reset();
    len = 4'd0;
    vld = 1'b1;
    prev_x = 1'b0;
    falls  = 0;
    for (int i = 1; i <= int'(GAP) + 2; i++) begin
      tick();
      vld  = 1'b0;
      want = {i >= int'(GAP), i <= int'(GAP), 1'b0, i == int'(GAP) + 1};
      n_checks++;
      if ({rdy, busy, x, done} !== want) begin
        n_fail++;
        $display("FAIL zero_len cyc %0d: got %b want %b", i, {rdy, busy, x, done}, want);
      end
      if (prev_x && !x) falls++;
      prev_x = x;
    end
    n_checks++;
    if (falls !== 0) begin
      n_fail++;
      $display("FAIL zero_detect: got %0d pulses want 0", falls);
    end
    len = LEN_W'(LEN_MAX);
    vld = 1'b1;
    falls = 0;
    for (int i = 1; i <= LEN_MAX + 3; i++) begin
      tick();
      vld  = 1'b0;
      want = {i >= LEN_MAX + 1, i <= LEN_MAX + 1, i <= LEN_MAX, i == LEN_MAX + 2};
      n_checks++;
      if ({rdy, busy, x, done} !== want) begin
        n_fail++;
        $display("FAIL max_len cyc %0d: got %b want %b", i, {rdy, busy, x, done}, want);
      end
      if (prev_x && !x) falls++;
      prev_x = x;
    end
    n_checks++;
    if (falls !== 1) begin
      n_fail++;
      $display("FAIL max_detect: got %0d pulses want 1", falls);
    end
  endtask

  task automatic test_async_reset;
    logic [3:0] want;
    apply_reset();
    len = 4'd5;
    vld = 1'b1;
    tick();
    vld = 1'b0;
    tick();
    n_checks++;
    if ({rdy, busy, x, done} !== 4'b0110) begin
      n_fail++;
      $display("FAIL areset_pre: got %b want 0110", {rdy, busy, x, done});
    end
    #2;
    r = 1'b0;
    #1;
    n_checks++;
    if ({rdy, busy, x, done} !== 4'b1000) begin
      n_fail++;
      $display("FAIL areset_now: got %b want 1000", {rdy, busy, x, done});
    end
    tick();
    n_checks++;
    if ({rdy, busy, x, done} !== 4'b1000) begin
      n_fail++;
      $display("FAIL areset_hold: got %b want 1000", {rdy, busy, x, done});
    end
    r   = 1'b1;
    len = 4'd2;
    vld = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      tick();
      vld  = 1'b0;
      want = {i >= 3, i <= 3, i <= 2, i == 4};
      n_checks++;
      if ({rdy, busy, x, done} !== want) begin
        n_fail++;
        $display("FAIL areset_next cyc %0d: got %b want %b", i, {rdy, busy, x, done}, want);
      end
    end
  endtask

  // Model: an accept at edge t gives ones on cycles t..t+l-1, zeros on
  // t+l..t+l+GAP-1, done on t+l+GAP, and readiness from t+l+GAP-1 on.
  task automatic test_random;
    logic [3:0] want;
    logic       prev_x;
    int         falls, exp_falls, next_free, t, l;
    bit         just_acc, exp_rdy;
    for (int i = 0; i < 2048; i++) begin
      exp_x[i] = 1'b0;
      exp_busy[i] = 1'b0;
      exp_done[i] = 1'b0;
    end
    apply_reset();
    next_free = 0;
    just_acc  = 1'b0;
    prev_x    = 1'b0;
    falls     = 0;
    exp_falls = 0;
    for (int k = 0; k < N_RAND; k++) begin
      exp_rdy = (k >= next_free);
      want = {exp_rdy, exp_busy[k], exp_x[k], exp_done[k]};
      n_checks++;
      if ({rdy, busy, x, done} !== want) begin
        n_fail++;
        $display("FAIL random cyc %0d: got %b want %b", k, {rdy, busy, x, done}, want);
      end
      if (prev_x && !x) falls++;
      prev_x = x;

      if (just_acc) begin
        vld = (($urandom % 2) == 1) && (k < N_RAND - 50);
        len = rand_len();
      end else if (!vld) begin
        if ((k < N_RAND - 50) && (($urandom % 3) == 0)) begin
          vld = 1'b1;
          len = rand_len();
        end else begin
          len = LEN_W'($urandom);
        end
      end else if (!exp_rdy && (($urandom % 8) == 0)) begin
        vld = 1'b0;
      end

      just_acc = 1'b0;
      if (vld && exp_rdy) begin
        t = k + 1;
        l = int'(len);
        for (int j = 0; j < l; j++) exp_x[t + j] = 1'b1;
        for (int j = 0; j < l + int'(GAP); j++) exp_busy[t + j] = 1'b1;
        exp_done[t + l + int'(GAP)] = 1'b1;
        next_free = t + l + int'(GAP) - 1;
        if (l > 0) exp_falls++;
        just_acc = 1'b1;
      end
      tick();
    end
    n_checks++;
    if (falls !== exp_falls) begin
      n_fail++;
      $display("FAIL random_detect: got %0d pulses want %0d", falls, exp_falls);
    end
  endtask

`ifdef RUNGEN_FRAMECNT_EN
  task automatic test_framecnt;
    int exp_cnt, n_done;
    apply_reset();
    len = 4'd1;
    vld = 1'b1;
    exp_cnt = 0;
    n_done  = 0;
    for (int i = 1; i <= 520; i++) begin
      tick();
      if (i == 513) vld = 1'b0;
      if ((i >= 3) && (i <= 515) && (i % 2 == 1)) exp_cnt++;
      if (done) n_done++;
      n_checks++;
      if (frames !== 8'(exp_cnt)) begin
        n_fail++;
        $display("FAIL frames cyc %0d: got %0d want %0d", i, frames, exp_cnt % 256);
      end
    end
    n_checks++;
    if (n_done !== 257) begin
      n_fail++;
      $display("FAIL frames_done: got %0d pulses want 257", n_done);
    end
    r = 1'b0;
    #1;
    n_checks++;
    if (frames !== 8'd0) begin
      n_fail++;
      $display("FAIL frames_reset: got %0d want 0", frames);
    end
    tick();
    r = 1'b1;
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_zero_and_max();
    test_async_reset();
    test_random();
`ifdef RUNGEN_FRAMECNT_EN
    test_framecnt();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/run_gen.md
Name: run_gen

Overview:
- Serial run-length transmitter: accepts a run-length word over a valid/ready handshake and emits a frame on the 1-bit serial line `x`.
- Frame format: `len` consecutive 1s, then `GAP` 0s.
- It is the sending end of the ones-run detector path. `x` feeds the detector's serial input directly, on the same clock.
- With `GAP`>=1, every frame with `len`>=1 produces exactly one detector `y` pulse.

Parameters:
- LEN_W, 4, width of the run-length word; max run = 2^LEN_W-1 ones.
- GAP, 1, number of 0 cycles after each run. Legal range 1..15; elaboration error outside it.

Ports:
- c  input  1  clock, rising edge.
- r  input  1  reset, asynchronous, active-low.
- len  input  LEN_W  run length (number of 1s) for the next frame.
- vld  input  1  `len` valid; held with `len` stable until accepted.
- rdy  output  1  transmitter can accept `len` this cycle.
- x  output  1  serial output, registered.
- busy  output  1  frame in progress (state != IDLE).
- done  output  1  one-cycle pulse after the last gap cycle of each frame.

Behaviour:
- State machine: IDLE, ONES, GAP. Registers: `st`, `cnt` [LEN_W-1:0], `gcnt` [3:0], `x`, `done`.
- Reset (`r`=0, asynchronous):
  - `st`=IDLE, `x`=0, `done`=0, `cnt`=0, `gcnt`=0.
  - `rdy` reads 1 during reset.
  - `vld` is ignored while `r`=0.
  - Reset mid-frame truncates the frame immediately; no `done` pulse.
- `rdy` is combinational: `rdy` = (`st`==IDLE) | (`st`==GAP & `gcnt`==0). Accept = `vld` & `rdy` at a rising edge.
- IDLE:
  - `x`=0.
  - Accept with `len`!=0: next `st`=ONES, `x`<=1, `cnt`<=`len`-1.
  - Accept with `len`==0: next `st`=GAP, `x`<=0, `gcnt`<=`GAP`-1. This is a gap-only frame.
  - No accept: stay in IDLE.
- ONES:
  - `cnt`!=0: `cnt`<=`cnt`-1, `x` stays 1.
  - `cnt`==0: `st`<=GAP, `x`<=0, `gcnt`<=`GAP`-1.
  - Result: `x` is high for exactly `len` consecutive cycles, starting the cycle after the accepting edge.
- GAP:
  - `gcnt`!=0: `gcnt`<=`gcnt`-1.
  - `gcnt`==0 with no accept: `st`<=IDLE, `done`<=1.
  - `gcnt`==0 with accept: the new frame loads exactly as from IDLE and `done`<=1 in the same edge. This gives back-to-back frames with no extra idle cycle.
- `done` is high only on the cycle following a completed frame's last gap cycle; it is cleared on every other edge.
- Back-to-back throughput: one frame per `len`+`GAP` cycles, with `len`>=1.
- Maximum `len` = 2^LEN_W-1. Counters never wrap, because every load value is <= its register maximum.
- `vld` dropped before acceptance is legal; nothing is loaded.
- `len` changing while `rdy`=0 has no effect.

Optional Feature:
- Macro: RUNGEN_FRAMECNT_EN.
- Defined:
  - Adds output port `frames`, 8 bits: count of completed frames, i.e. the number of `done` pulses.
  - `frames` increments on the same edge that sets `done`, wraps 255->0, and resets to 0 on `r`=0.
  - Gap-only frames count.
- Undefined: the `frames` port and its register are absent; all other behaviour is identical.

Test Plan:
- Reset with `r`=0 for 3 cycles, then release -> `x`=0, `busy`=0, `done`=0, `rdy`=1; no activity on `x` with `vld`=0 for 10 cycles.
- `len`=3, `GAP`=1, single accept -> `x`=1,1,1,0 on cycles 1-4 after the accept edge; `done`=1 on cycle 5; detector `y` pulses once (cycle 4).
- `vld` held high with `len`=2 for 3 frames, `GAP`=1 -> `x` pattern 110110110 with no idle cycle; 3 `done` pulses, spaced 3 cycles apart; 3 detector pulses.
- `len`=0 -> `x` stays 0 for `GAP` cycles, then `done` pulses; detector never pulses. Also `len`=15 with `LEN_W`=4 -> exactly 15 ones.
- Assert `r`=0 asynchronously at the 2nd cycle of `len`=5 ONES -> `x` drops to 0 immediately; no `done`; the next accepted frame is clean.
- With RUNGEN_FRAMECNT_EN defined: 257 frames of `len`=1 -> `frames`=1 after completion; a reset clears it to 0.
